// File: rtl/bcd_scan_display_pkg.sv
// Shared widths and 7-segment patterns (g..a, active-high) for the BCD scan display.
package bcd_scan_display_pkg;

  localparam int BCD_W  = 4;
  localparam int DIGITS = 4;
  localparam int PRE_W  = 8;
  localparam int SCAN_W = 2;
  localparam int SEG_W  = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

  // Codes 10..15 are not digits and light nothing.
  function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [BCD_W-1:0] code);
    case (code)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_scan_display_dec.sv
// bcd_seg_decoder: combinational BCD -> 7-segment decode with a blank override.
module bcd_seg_decoder
  import bcd_scan_display_pkg::*;
(
  input  logic [BCD_W-1:0] code,
  input  logic             blank,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) seg = bcd_to_seg(code);
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Four-digit multiplexed BCD display driver: capture on load, prescaled scan, 7-seg decode.
// Optional leading-zero blanking when BCD_SCAN_LZB_EN is defined.
module bcd_scan_display
  import bcd_scan_display_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [DIGITS*BCD_W-1:0] d,
  input  logic                    load,
  input  logic                    bi,
  output logic [SEG_W-1:0]        seg,
  output logic [DIGITS-1:0]       dig,
  output logic [SCAN_W-1:0]       slot
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [DIGITS-1:0][BCD_W-1:0] latch_q;
  logic [PRE_W-1:0]             pre_q;
  logic [SCAN_W-1:0]            scan_q;
  logic                         wrap;
  logic [DIGITS-1:0]            lzb;
  logic                         blank_slot;

  always_ff @(posedge clk or posedge clr) begin
    if (clr)       latch_q <= '0;
    else if (!load) latch_q <= d;
  end

  assign wrap = (pre_q == PRE_LAST);

  // PRESCALE=1 leaves pre_q at 0, so wrap holds and scan steps every clock.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pre_q  <= '0;
      scan_q <= '0;
    end else if (wrap) begin
      pre_q  <= '0;
      scan_q <= scan_q + 2'd1;
    end else begin
      pre_q  <= pre_q + 8'd1;
    end
  end

`ifdef BCD_SCAN_LZB_EN
  logic [DIGITS-1:0] dz, hz;
  for (genvar k = 0; k < DIGITS; k++) begin : g_dz
    assign dz[k] = (latch_q[k] == '0);
  end
  // hz[k]: digit k and every digit above it are zero; invalid codes read as nonzero.
  assign hz[DIGITS-1] = dz[DIGITS-1];
  for (genvar k = DIGITS-2; k >= 0; k--) begin : g_hz
    assign hz[k] = dz[k] & hz[k+1];
  end
  assign lzb = {hz[DIGITS-1:1], 1'b0};
`else
  assign lzb = '0;
`endif

  assign blank_slot = ~bi | lzb[scan_q];
  assign slot       = scan_q;

  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    assign dig[k] = blank_slot | (scan_q != SCAN_W'(k));
  end

  bcd_seg_decoder u_dec (
    .code  (latch_q[scan_q]),
    .blank (blank_slot),
    .seg   (seg)
  );

endmodule
